// File: rtl/ram_access_ctrl_pkg.sv
// Shared definitions for the RAM access controller: FSM states, default
// geometry and the address range helper used by the row decoders.
package ram_access_ctrl_pkg;

  localparam int DEF_DW   = 11;
  localparam int DEF_ROWS = 16;
  localparam int DEF_AW   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // True when a row address falls inside the populated rows.
  function automatic logic addr_in_range(input logic [31:0] addr, input int rows);
    return (addr < 32'(rows));
  endfunction

endpackage

// File: rtl/ram_row_decoder.sv
// Address to one-hot row decoder. Addresses beyond the populated rows
// decode to an all-zero vector and clear the range flag.
module ram_row_decoder
  import ram_access_ctrl_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int ROWS = DEF_ROWS
) (
  input  logic            i_en,
  input  logic [AW-1:0]   i_addr,
  output logic [ROWS-1:0] o_sel,
  output logic            o_in_range
);

  // Gated one-hot decode; the range flag is independent of the enable.
  always_comb begin
    o_sel      = '0;
    o_in_range = addr_in_range(32'(i_addr), ROWS);
    for (int i = 0; i < ROWS; i++) begin
      if (i_en && (32'(i_addr) == 32'(i))) begin
        o_sel[i] = 1'b1;
      end else begin
        o_sel[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Request/response front end for a row-organised RAM. A request is taken
// in IDLE, drives the row selects for exactly one cycle (WRITE or READ) and
// is then presented as a held response until the consumer accepts it.
// Selects are decoded from the request inputs and registered on the accept
// edge so they are active in the very next cycle.
module ram_access_ctrl
  import ram_access_ctrl_pkg::*;
#(
  parameter int DW   = DEF_DW,
  parameter int ROWS = DEF_ROWS,
  parameter int AW   = DEF_AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr_1,
  input  logic [AW-1:0]   req_addr_2,
  input  logic [DW-1:0]   req_wdata,
  output logic [DW-1:0]   Write_Data,
  output logic [ROWS-1:0] Write_Select,
  output logic [ROWS-1:0] Read_Select_1,
  output logic [ROWS-1:0] Read_Select_2,
  input  logic [DW-1:0]   Read_Data_1,
  input  logic [DW-1:0]   Read_Data_2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data_1,
  output logic [DW-1:0]   rsp_data_2,
  output logic            rsp_err
);

  state_t          r_state;
  logic            r_oor_1;
  logic            r_oor_2;

  logic [ROWS-1:0] w_wr_sel;
  logic [ROWS-1:0] w_rd1_sel;
  logic [ROWS-1:0] w_rd2_sel;
  logic            w_wr_in_range;
  logic            w_rd1_in_range;
  logic            w_rd2_in_range;
  logic            w_accept;

  assign w_accept = req_valid && req_ready;

  ram_row_decoder #(.AW(AW), .ROWS(ROWS)) u_wr_dec (
    .i_en       (req_we),
    .i_addr     (req_addr_1),
    .o_sel      (w_wr_sel),
    .o_in_range (w_wr_in_range)
  );

  ram_row_decoder #(.AW(AW), .ROWS(ROWS)) u_rd1_dec (
    .i_en       (!req_we),
    .i_addr     (req_addr_1),
    .o_sel      (w_rd1_sel),
    .o_in_range (w_rd1_in_range)
  );

  ram_row_decoder #(.AW(AW), .ROWS(ROWS)) u_rd2_dec (
    .i_en       (!req_we),
    .i_addr     (req_addr_2),
    .o_sel      (w_rd2_sel),
    .o_in_range (w_rd2_in_range)
  );

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_oor_1       <= 1'b0;
      r_oor_2       <= 1'b0;
      req_ready     <= 1'b1;
      Write_Data    <= '0;
      Write_Select  <= '0;
      Read_Select_1 <= '0;
      Read_Select_2 <= '0;
      rsp_valid     <= 1'b0;
      rsp_data_1    <= '0;
      rsp_data_2    <= '0;
      rsp_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            req_ready <= 1'b0;
            if (req_we) begin
              // Write_Data keeps this value after the write cycle.
              Write_Data   <= req_wdata;
              Write_Select <= w_wr_sel;
              r_oor_1      <= !w_wr_in_range;
              r_oor_2      <= 1'b0;
              r_state      <= WRITE;
            end else begin
              Read_Select_1 <= w_rd1_sel;
              Read_Select_2 <= w_rd2_sel;
              r_oor_1       <= !w_rd1_in_range;
              r_oor_2       <= !w_rd2_in_range;
              r_state       <= READ;
            end
          end else begin
            req_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end

        WRITE: begin
          Write_Select <= '0;
          rsp_data_1   <= '0;
          rsp_data_2   <= '0;
          rsp_err      <= r_oor_1;
          rsp_valid    <= 1'b1;
          r_state      <= RESP;
        end

        READ: begin
          Read_Select_1 <= '0;
          Read_Select_2 <= '0;
          // An out-of-range port had no row selected; report zero for it.
          if (r_oor_1) begin
            rsp_data_1 <= '0;
          end else begin
            rsp_data_1 <= Read_Data_1;
          end
          if (r_oor_2) begin
            rsp_data_2 <= '0;
          end else begin
            rsp_data_2 <= Read_Data_2;
          end
          rsp_err   <= r_oor_1 | r_oor_2;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
            r_state   <= RESP;
          end
        end

        default: begin
          r_state       <= IDLE;
          req_ready     <= 1'b1;
          Write_Select  <= '0;
          Read_Select_1 <= '0;
          Read_Select_2 <= '0;
          rsp_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl with a behavioural row RAM attached
// to the select/data buses. Expected responses are queued when a request is
// driven and compared when the response handshake occurs.
module tb_ram_access_ctrl;

  localparam int DW   = 11;
  localparam int ROWS = 12;
  localparam int AW   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr_1;
  logic [AW-1:0]   req_addr_2;
  logic [DW-1:0]   req_wdata;
  logic [DW-1:0]   Write_Data;
  logic [ROWS-1:0] Write_Select;
  logic [ROWS-1:0] Read_Select_1;
  logic [ROWS-1:0] Read_Select_2;
  logic [DW-1:0]   Read_Data_1;
  logic [DW-1:0]   Read_Data_2;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data_1;
  logic [DW-1:0]   rsp_data_2;
  logic            rsp_err;

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  int            acc_q[$];
  logic [DW-1:0] exp_mem [ROWS];
  logic [DW-1:0] ram [ROWS];
  logic          ram_init_done = 1'b0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;

  ram_access_ctrl #(.DW(DW), .ROWS(ROWS), .AW(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr_1    (req_addr_1),
    .req_addr_2    (req_addr_2),
    .req_wdata     (req_wdata),
    .Write_Data    (Write_Data),
    .Write_Select  (Write_Select),
    .Read_Select_1 (Read_Select_1),
    .Read_Select_2 (Read_Select_2),
    .Read_Data_1   (Read_Data_1),
    .Read_Data_2   (Read_Data_2),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data_1    (rsp_data_1),
    .rsp_data_2    (rsp_data_2),
    .rsp_err       (rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 145 + 9);
  endfunction

  // Row RAM: writes on selected rows, read data merged by OR over selected rows.
  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < ROWS; i++) ram[i] <= init_val(i);
      ram_init_done <= 1'b1;
    end else begin
      for (int i = 0; i < ROWS; i++) if (Write_Select[i]) ram[i] <= Write_Data;
    end
  end

  always_comb begin
    Read_Data_1 = '0;
    Read_Data_2 = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (Read_Select_1[i]) Read_Data_1 = Read_Data_1 | ram[i];
      if (Read_Select_2[i]) Read_Data_2 = Read_Data_2 | ram[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Response monitor: pops the scoreboard on each handshake, logs accepts.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      if (req_valid && req_ready) acc_q.push_back(cyc);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data_1", 32'(rsp_data_1), 32'(e.d1));
          chk("rsp_data_2", 32'(rsp_data_2), 32'(e.d2));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic push_exp(input logic we, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [DW-1:0] wd);
    exp_t e;
    if (we) begin
      e.d1  = '0;
      e.d2  = '0;
      e.err = (32'(a1) >= ROWS);
      if (32'(a1) < ROWS) exp_mem[a1] = wd;
    end else begin
      e.d1  = (32'(a1) < ROWS) ? exp_mem[a1] : '0;
      e.d2  = (32'(a2) < ROWS) ? exp_mem[a2] : '0;
      e.err = (32'(a1) >= ROWS) || (32'(a2) >= ROWS);
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(output logic ok);
    int waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    ok = req_ready;
    if (!ok) chk("accept_timeout", 32'(req_ready), 32'(1));
  endtask

  // One transaction with cycle-accurate select / latency checks.
  task automatic txn(input logic we, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                     input logic [DW-1:0] wd, input int hold);
    logic [ROWS-1:0] ew;
    logic [ROWS-1:0] er1;
    logic [ROWS-1:0] er2;
    logic            ok;
    ew  = '0;
    er1 = '0;
    er2 = '0;
    if (we && 32'(a1) < ROWS) ew[a1] = 1'b1;
    if (!we && 32'(a1) < ROWS) er1[a1] = 1'b1;
    if (!we && 32'(a2) < ROWS) er2[a2] = 1'b1;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr_1 = a1;
    req_addr_2 = a2;
    req_wdata  = wd;
    rsp_ready  = (hold == 0);
    wait_ready(ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    push_exp(we, a1, a2, wd);
    @(negedge clk);
    req_valid = 1'b0;
    chk("wsel_n1", 32'(Write_Select), 32'(ew));
    chk("rsel1_n1", 32'(Read_Select_1), 32'(er1));
    chk("rsel2_n1", 32'(Read_Select_2), 32'(er2));
    chk("rsp_valid_n1", 32'(rsp_valid), 32'(0));
    chk("req_ready_busy", 32'(req_ready), 32'(0));
    if (we) chk("wdata_n1", 32'(Write_Data), 32'(wd));
    @(negedge clk);
    chk("wsel_n2", 32'(Write_Select), 32'(0));
    chk("rsel_n2", 32'({Read_Select_1, Read_Select_2}), 32'(0));
    chk("rsp_valid_n2", 32'(rsp_valid), 32'(1));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'(1));
      chk("hold_req_ready", 32'(req_ready), 32'(0));
      if (exp_q.size() > 0) begin
        chk("hold_data_1", 32'(rsp_data_1), 32'(exp_q[0].d1));
        chk("hold_data_2", 32'(rsp_data_2), 32'(exp_q[0].d2));
        chk("hold_err", 32'(rsp_err), 32'(exp_q[0].err));
      end else begin
        chk("hold_queue", 32'(exp_q.size()), 32'(1));
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'(1));
    chk("idle_rsp_valid", 32'(rsp_valid), 32'(0));
  endtask

  initial begin
    logic ok;
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   waited;
    for (int i = 0; i < ROWS; i++) exp_mem[i] = init_val(i);
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr_1 = '0;
    req_addr_2 = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp", 32'({rsp_err, rsp_data_1, rsp_data_2}), 32'(0));
    chk("rst_wdata", 32'(Write_Data), 32'(0));
    chk("rst_sel", 32'({Write_Select, Read_Select_1}), 32'(0));
    chk("rst_sel2", 32'(Read_Select_2), 32'(0));
    reset = 1'b1;

    txn(1'b1, 4'd3, 4'd0, 11'h5A5, 0);
    chk("wsel_row3_pattern", 32'(dut.Write_Data), 32'(11'h5A5));
    txn(1'b1, 4'd7, 4'd0, 11'h123, 0);
    txn(1'b0, 4'd3, 4'd7, 11'h000, 5);
    txn(1'b0, 4'd13, 4'd2, 11'h000, 0);
    txn(1'b1, 4'd12, 4'd0, 11'h7FF, 0);
    txn(1'b1, 4'd11, 4'd0, 11'h6C3, 0);
    txn(1'b0, 4'd11, 4'd12, 11'h000, 1);
    txn(1'b0, 4'd0, 4'd15, 11'h000, 0);

    // Reset in the middle of a read: no response may follow.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr_1 = 4'd3;
    req_addr_2 = 4'd7;
    rsp_ready  = 1'b1;
    wait_ready(ok);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_rsel_active", 32'(Read_Select_1), 32'(12'h008));
    reset = 1'b0;
    @(negedge clk);
    chk("abort_sel", 32'({Read_Select_1, Read_Select_2}), 32'(0));
    chk("abort_outs", 32'({rsp_valid, rsp_err, rsp_data_1, rsp_data_2}), 32'(0));
    chk("abort_wsel", 32'(Write_Select), 32'(0));
    chk("abort_req_ready", 32'(req_ready), 32'(1));
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'(0));
    end

    // Back-to-back write then read of row 0 with the requester always valid.
    acc_q.delete();
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr_1 = 4'd0;
    req_addr_2 = 4'd0;
    req_wdata  = 11'h2B7;
    rsp_ready  = 1'b1;
    wait_ready(ok);
    push_exp(1'b1, 4'd0, 4'd0, 11'h2B7);
    @(negedge clk);
    req_we = 1'b0;
    wait_ready(ok);
    push_exp(1'b0, 4'd0, 4'd0, 11'h000);
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (acc_q.size() == 2) chk("b2b_spacing", 32'(acc_q[1] - acc_q[0]), 32'(3));
    else chk("b2b_accepts", 32'(acc_q.size()), 32'(2));

    // Random mix, including out-of-range addresses.
    for (int n = 0; n < 10; n++) begin
      txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), AW'($urandom_range(0, 13)),
          DW'($urandom), int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameter DW, default 11, RAM row data width in bits.
REQ-002 Parameter ROWS, default 16, number of RAM rows driven.
REQ-003 Parameter AW, default 4, address width; 2**AW >= ROWS.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset, with ports named clk and reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_we  input  1  1 = write, 0 = dual read.
REQ-010 req_addr_1  input  AW  write address, or read port 1 address.
REQ-011 req_addr_2  input  AW  read port 2 address; ignored on write.
REQ-012 req_wdata  input  DW  write data.
REQ-013 Write_Data  output  DW  data bus to all rows.
REQ-014 Write_Select  output  ROWS  one-hot row write enables.
REQ-015 Read_Select_1 / Read_Select_2  output  ROWS each  one-hot row read enables.
REQ-016 Read_Data_1 / Read_Data_2  input  DW each  merged row read data.
REQ-017 rsp_valid  output  1  response present.
REQ-018 rsp_ready  input  1  consumer accepts the response.
REQ-019 rsp_data_1 / rsp_data_2  output  DW each  captured read data.
REQ-020 rsp_err  output  1  request address was out of range.

Function
REQ-021 The FSM SHALL have four states: IDLE, WRITE, READ and RESP.
REQ-022 req_ready SHALL equal 1 only in IDLE; a request is accepted on the edge where req_valid && req_ready is true.
REQ-023 On acceptance, the block SHALL register req_we, both addresses and req_wdata, then go to WRITE if req_we is 1, else to READ.
REQ-024 WRITE SHALL last exactly one cycle, with Write_Data = registered data and Write_Select = onehot(addr_1), then go to RESP.
REQ-025 READ SHALL last exactly one cycle, with Read_Select_1 = onehot(addr_1) and Read_Select_2 = onehot(addr_2).
REQ-026 At the end of READ, Read_Data_1/2 SHALL be captured into rsp_data_1/2, then the FSM goes to RESP.
REQ-027 Latency SHALL be: accept at edge N, select lines active in cycle N+1, rsp_valid = 1 from cycle N+2.
REQ-028 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_err SHALL be held stable until rsp_ready = 1.
REQ-029 On the edge where rsp_valid && rsp_ready, the FSM SHALL return to IDLE.
REQ-030 A write response SHALL carry rsp_data_1 = rsp_data_2 = 0.
REQ-031 Outside WRITE, all Write_Select bits SHALL be 0; outside READ, all Read_Select bits SHALL be 0.
REQ-032 Any address >= ROWS SHALL drive an all-zero select vector, force the corresponding rsp_data to 0, and set rsp_err = 1.
REQ-033 Write_Data SHALL hold its last value outside WRITE.
REQ-034 Back-to-back requests SHALL give a minimum of 3 cycles per transaction; read-after-write to the same row SHALL return the new data.
REQ-035 A req_valid that arrives while the block is busy SHALL be ignored until IDLE; the requester must hold it.

Reset
REQ-036 With reset = 0 at an edge, the block SHALL go to IDLE and zero rsp_valid, rsp_err, rsp_data_1/2, Write_Data, and all select vectors.
REQ-037 After reset, req_ready SHALL be 1.
REQ-038 Reset during WRITE or READ SHALL abort the transaction, with no select active in the following cycle and no response issued.

Structure
REQ-039 A shared package SHALL hold the state enum (IDLE, WRITE, READ, RESP) and the default DW/ROWS/AW constants.
REQ-040 One sub-module, ram_row_decoder (AW to ROWS one-hot with enable and range flag), SHALL be instantiated three times.

Verification
REQ-041 Reset, then write addr 3 data 11'h5A5 -> Write_Select = 16'h0008 for exactly one cycle; rsp_valid at N+2; rsp_err = 0.
REQ-042 Model rows 3 = 11'h5A5 and 7 = 11'h123, then read addr_1 = 3, addr_2 = 7 -> rsp_data_1 = 11'h5A5, rsp_data_2 = 11'h123.
REQ-043 With ROWS = 12, read addr 13 -> Read_Select_1 = 0, rsp_data_1 = 0, rsp_err = 1.
REQ-044 Hold rsp_ready = 0 for 5 cycles -> rsp_valid and the data stay stable, req_ready = 0; release -> IDLE on the next cycle.
REQ-045 Assert reset = 0 during READ -> no response; all outputs zero next cycle; req_ready = 1.
REQ-046 Write then read of addr 0 back-to-back with the requester always valid -> 3-cycle spacing; the read returns the written value.
